// File: rtl/score_seg_scan.sv
// Three-digit multiplexed seven-segment driver for the Snake score.
// Latches the score once per scan frame, blanks leading zeros, blinks on game over.
module score_seg_scan #(
    parameter int SCAN_DIV     = 25000,
    parameter int BLINK_FRAMES = 83
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_data,
    input  logic [1:0]  game_status,
    output logic [2:0]  sel,
    output logic [7:0]  seg
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OVER = 2'd2;

    logic [DW-1:0] div_cnt;
    logic [1:0]    idx;
    logic [11:0]   shadow;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    logic          tick;
    logic          frame_end;
    logic [3:0]    nib;
    logic          blank;
    logic [7:0]    seg_next;
    logic [2:0]    sel_next;

    function automatic logic [7:0] decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'h86;
        endcase
        return s;
    endfunction

    assign tick      = (div_cnt == DIV_LAST);
    assign frame_end = tick && (idx == 2'd2);
    assign sel_next  = ~(3'b001 << idx);

    always_comb begin
        nib   = shadow[3:0];
        blank = 1'b0;
        case (idx)
            2'd1: begin
                nib   = shadow[7:4];
                blank = (shadow[11:4] == 8'h00);
            end
            2'd2: begin
                nib   = shadow[11:8];
                blank = (shadow[11:8] == 4'h0);
            end
            default: begin
                nib   = shadow[3:0];
                blank = 1'b0;
            end
        endcase

        // Priority: idle dashes, then blink-dark, then leading-zero blank.
        if (game_status == ST_IDLE)
            seg_next = 8'hBF;
        else if (game_status == ST_OVER && !blink_on)
            seg_next = 8'hFF;
        else if (blank)
            seg_next = 8'hFF;
        else
            seg_next = decode(nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            idx       <= 2'd0;
            shadow    <= 12'h000;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            sel       <= 3'b111;
            seg       <= 8'hFF;
        end else begin
            sel <= sel_next;
            seg <= seg_next;

            div_cnt <= tick ? '0 : div_cnt + 1'b1;

            if (tick)
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;

            if (frame_end)
                shadow <= bcd_data;

            if (game_status != ST_OVER) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_seg_scan.sv
// Scoreboard bench for score_seg_scan: per-cycle model queue plus directed
// slot checks against fixed segment codes.
module tb_score_seg_scan;

    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bcd_data = 12'h000;
    logic [1:0]  game_status = 2'd1;
    logic [2:0]  sel;
    logic [7:0]  seg;

    int checks   = 0;
    int failures = 0;

    logic [10:0] sb_q[$];

    int          m_div;
    int          m_idx;
    logic [11:0] m_shadow;
    int          m_bcnt;
    logic        m_bon;

    score_seg_scan #(
        .SCAN_DIV(SD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bcd_data(bcd_data),
        .game_status(game_status),
        .sel(sel),
        .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_seg(input logic [3:0] d);
        logic [7:0] tbl[10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        if (d > 4'd9) return 8'h86;
        return tbl[d];
    endfunction

    task automatic step();
        logic [2:0] es;
        logic [7:0] eg;
        logic [3:0] d;
        logic [10:0] e;
        if (rst) begin
            es = 3'b111;
            eg = 8'hFF;
            m_div = 0; m_idx = 0; m_shadow = 12'h000;
            m_bcnt = 0; m_bon = 1'b1;
        end else begin
            es = (m_idx == 0) ? 3'b110 : (m_idx == 1) ? 3'b101 : 3'b011;
            d  = (m_idx == 0) ? m_shadow[3:0] :
                 (m_idx == 1) ? m_shadow[7:4] : m_shadow[11:8];
            if (game_status == 2'd0) eg = 8'hBF;
            else if (game_status == 2'd2 && !m_bon) eg = 8'hFF;
            else if (m_idx == 2 && m_shadow[11:8] == 0) eg = 8'hFF;
            else if (m_idx == 1 && m_shadow[11:4] == 0) eg = 8'hFF;
            else eg = ref_seg(d);
            if (m_div == SD - 1) begin
                m_div = 0;
                if (m_idx == 2) begin
                    m_shadow = bcd_data;
                    if (game_status == 2'd2) begin
                        if (m_bcnt == BF - 1) begin
                            m_bcnt = 0;
                            m_bon = !m_bon;
                        end else m_bcnt++;
                    end
                    m_idx = 0;
                end else m_idx++;
            end else m_div++;
            if (game_status != 2'd2) begin
                m_bcnt = 0;
                m_bon = 1'b1;
            end
        end
        sb_q.push_back({es, eg});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("cyc", {sel, seg}, e);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_sel(input logic [2:0] target);
        for (int i = 0; i < 20; i++) begin
            step();
            if (sel === target) return;
        end
        check("wait_sel_timeout", sel, target);
    endtask

    task automatic show(input string tag, input logic [11:0] v,
                        input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2);
        bcd_data = v;
        steps(3 * SD + 1);
        wait_sel(3'b110); check({tag, "_ones"}, seg, e0);
        wait_sel(3'b101); check({tag, "_tens"}, seg, e1);
        wait_sel(3'b011); check({tag, "_hund"}, seg, e2);
    endtask

    initial begin
        int dark;
        rst = 1'b1;
        game_status = 2'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_sel", sel, 3'b111);
            check("rst_seg", seg, 8'hFF);
        end
        rst = 1'b0;
        step();
        check("first_sel", sel, 3'b110);
        check("first_seg", seg, 8'hC0);
        steps(SD);
        check("rot_tens", sel, 3'b101);
        steps(SD);
        check("rot_hund", sel, 3'b011);
        steps(SD);
        check("rot_wrap", sel, 3'b110);

        show("s305", 12'h305, 8'h92, 8'hC0, 8'hB0);
        show("s007", 12'h007, 8'hF8, 8'hFF, 8'hFF);
        show("s040", 12'h040, 8'hC0, 8'h99, 8'hFF);

        show("s111", 12'h111, 8'hF9, 8'hF9, 8'hF9);
        wait_sel(3'b101);
        bcd_data = 12'h222;
        check("mid_tens", seg, 8'hF9);
        wait_sel(3'b011); check("mid_hund", seg, 8'hF9);
        wait_sel(3'b110); check("new_ones", seg, 8'hA4);
        wait_sel(3'b101); check("new_tens", seg, 8'hA4);
        wait_sel(3'b011); check("new_hund", seg, 8'hA4);

        game_status = 2'd0;
        step();
        check("idle_now", seg, 8'hBF);
        wait_sel(3'b110); check("idle_ones", seg, 8'hBF);
        wait_sel(3'b101); check("idle_tens", seg, 8'hBF);
        wait_sel(3'b011); check("idle_hund", seg, 8'hBF);

        bcd_data = 12'h012;
        game_status = 2'd1;
        steps(3 * SD + 1);
        game_status = 2'd2;
        steps(3 * SD * 5);
        dark = 0;
        for (int i = 0; i < 3 * SD * 4 && !dark; i++) begin
            step();
            if (sel === 3'b110 && seg === 8'hFF) dark = 1;
        end
        check("blink_dark", dark, 1);
        game_status = 2'd1;
        step();
        check("wake", (seg === 8'hFF) ? 1 : 0, 0);

        show("s1a3", 12'h1A3, 8'hB0, 8'h86, 8'hF9);
        step();
        rst = 1'b1;
        step();
        check("mrst_sel", sel, 3'b111);
        check("mrst_seg", seg, 8'hFF);
        rst = 1'b0;
        step();
        check("post_sel", sel, 3'b110);
        check("post_seg", seg, 8'hC0);
        steps(SD);
        check("post_tens", seg, 8'hFF);
        steps(SD);
        check("post_hund", seg, 8'hFF);
        steps(2 * SD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
